// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the power-LED button controller.
//
// Contents:
//   btn_state_t              press-classification FSM states
//   CLK_HZ                   system clock frequency the default timings assume
//   DEFAULT_DEBOUNCE_CYCLES  10 ms worth of clk cycles
//   DEFAULT_LONG_CYCLES      1 s worth of clk cycles
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int unsigned CLK_HZ                  = 27_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int unsigned DEFAULT_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: two-flop synchroniser on the raw active-low button followed by a
// stable-level counter. A new level is accepted once the synchronised input has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive samples.
//
// Ports:
//   clk      system clock, posedge
//   rst_n    synchronous active-low reset
//   btn_n    raw asynchronous button, 0 = pressed
//   restart  veto the acceptance signalled by `changed` this cycle: the accepted
//            level is kept and the count starts over
//   stable   accepted button level, 1 = pressed
//   changed  high during the cycle whose posedge accepts a new level
//            (combinational strobe from registered state)
//
// DEBOUNCE_CYCLES must be >= 2.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic restart,
  output logic stable,
  output logic changed
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q;
  logic            sync2_q;
  logic            pressed;
  logic [CntW-1:0] db_cnt_q;
  logic [CntW-1:0] db_cnt_d;
  logic            stable_q;
  logic            stable_d;

  assign pressed = ~sync2_q;

  // The sample at this edge is the DEBOUNCE_CYCLES-th consecutive differing one.
  assign changed = (pressed != stable_q) && (db_cnt_q == CntLast);

  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (pressed == stable_q) begin
      // Any sample back at the accepted level restarts the count (bounce).
      db_cnt_d = '0;
    end else if (changed) begin
      db_cnt_d = '0;
      if (!restart) begin
        stable_d = pressed;
      end
    end else if (db_cnt_q != CntMax) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/led_btn_ctrl.sv
// led_btn_ctrl: conditions the power-LED push button and produces the `sw` enable
// level for the breathing PWM stage. Each debounced press is classified as short
// (toggles sw on release) or long (one-cycle event pulse when the hold time is
// reached; sw untouched).
//
// Ports:
//   clk          system clock, posedge
//   rst_n        synchronous active-low reset
//   btn_n        raw asynchronous button, 0 = pressed
//   sw           LED enable to the PWM stage, 1 = running (reset value INIT_EN)
//   btn_level    debounced button state, 1 = pressed
//   short_pulse  one-cycle pulse when a short press is released
//   long_pulse   one-cycle pulse when a press reaches LONG_CYCLES
//
// LONG_CYCLES is counted from the cycle the press is accepted and must exceed
// DEBOUNCE_CYCLES. All outputs come straight from flops.
module led_btn_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit          INIT_EN         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic sw,
  output logic btn_level,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);

  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [HoldW-1:0] hold_cnt_q;
  logic [HoldW-1:0] hold_cnt_d;
  logic             sw_q;
  logic             sw_d;
  logic             btn_level_q;
  logic             btn_level_d;
  logic             short_q;
  logic             short_d;
  logic             long_q;
  logic             long_d;

  logic db_stable;
  logic db_changed;
  logic press_acc;
  logic release_acc;
  logic hold_done;
  logic db_restart;

  // Long wins over a release accepted on the same edge; the debouncer then keeps
  // "pressed" so the release is debounced again from LONG.
  assign hold_done  = (state_q == PRESSED) && (hold_cnt_q == HoldLast);
  assign db_restart = hold_done && release_acc;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .restart(db_restart),
    .stable (db_stable),
    .changed(db_changed)
  );

  assign press_acc   = db_changed && !db_stable;
  assign release_acc = db_changed && db_stable;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    sw_d       = sw_q;
    short_d    = 1'b0;
    long_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (press_acc) begin
          state_d = PRESSED;
        end
      end

      PRESSED: begin
        hold_cnt_d = (hold_cnt_q != HoldMax) ? hold_cnt_q + 1'b1 : hold_cnt_q;
        if (hold_done) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else if (release_acc) begin
          state_d = IDLE;
          short_d = 1'b1;
          sw_d    = ~sw_q;
        end
      end

      LONG: begin
        // A stuck button parks here; no repeated events.
        if (release_acc) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    btn_level_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      sw_q        <= INIT_EN;
      btn_level_q <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sw_q        <= sw_d;
      btn_level_q <= btn_level_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  assign sw          = sw_q;
  assign btn_level   = btn_level_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;

endmodule

// File: tb/tb_led_btn_ctrl.sv
// Scoreboard bench for led_btn_ctrl (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, INIT_EN=1).
// Stimulus tasks push the expected output events (cycle + output snapshot) when
// they drive the button; a negedge monitor pops one entry for every cycle in
// which a pulse is high or sw/btn_level changes.
module tb_led_btn_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned LC = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_n;
  logic sw;
  logic btn_level;
  logic short_pulse;
  logic long_pulse;

  int unsigned cyc      = 0;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [3:0]  snap;  // {sw, btn_level, short_pulse, long_pulse}
  } ev_t;

  ev_t  sb_q[$];
  logic exp_sw;
  logic mon_en = 1'b0;
  logic prev_sw;
  logic prev_lvl;

  led_btn_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .INIT_EN        (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .sw         (sw),
    .btn_level  (btn_level),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input string name, input int unsigned c, input logic [3:0] snap);
    ev_t e;
    e.name = name;
    e.cyc  = c;
    e.snap = snap;
    sb_q.push_back(e);
  endtask

  // Press driven (btn_n=0) at cycle a, released at a+h. The input reaches the
  // FSM 2 cycles later and needs DB samples, so edges land at a+2+DB and
  // a+h+2+DB; long fires LC cycles after the press is accepted.
  task automatic expect_press(input int unsigned a, input int unsigned h);
    int unsigned t_rise;
    int unsigned t_rel;
    int unsigned t_long;
    t_rise = a + 2 + DB;
    t_rel  = a + h + 2 + DB;
    t_long = t_rise + LC;
    push_ev("press_rise", t_rise, {exp_sw, 3'b100});
    if (t_rel < t_long) begin
      exp_sw = ~exp_sw;
      push_ev("short_release", t_rel, {exp_sw, 3'b010});
    end else begin
      push_ev("long_pulse", t_long, {exp_sw, 3'b101});
      // A release coinciding with the long edge is debounced again from scratch.
      push_ev("long_release", (t_rel == t_long) ? t_long + DB : t_rel, {exp_sw, 3'b000});
    end
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_press(input string tag, input int unsigned h);
    int unsigned a;
    a = cyc;
    btn_n = 1'b0;
    expect_press(a, h);
    wait_to(a + h);
    btn_n = 1'b1;
    wait_to(a + h + 2 * DB + 8);
    check({tag, "_drain"}, sb_q.size(), 0);
    check({tag, "_sw"}, sw, exp_sw);
    check({tag, "_level"}, btn_level, 0);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en) begin
      if (short_pulse || long_pulse || btn_level != prev_lvl || sw != prev_sw) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", {cyc, sw, btn_level, short_pulse, long_pulse}, 0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_cycle"}, cyc, e.cyc);
          check({e.name, "_outputs"}, {sw, btn_level, short_pulse, long_pulse}, e.snap);
        end
      end
      prev_lvl <= btn_level;
      prev_sw  <= sw;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;

    // Reset with the button already held.
    rst_n = 1'b0;
    btn_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sw", sw, 1);
    check("rst_level", btn_level, 0);
    check("rst_short", short_pulse, 0);
    check("rst_long", long_pulse, 0);
    exp_sw   = 1'b1;
    prev_sw  = sw;
    prev_lvl = btn_level;
    mon_en   = 1'b1;

    // Held through reset release for 40 cycles: rise 6 later, long 20 after that.
    a = cyc;
    rst_n = 1'b1;
    expect_press(a, 40);
    wait_to(a + 40);
    btn_n = 1'b1;
    wait_to(a + 40 + 2 * DB + 8);
    check("hold40_drain", sb_q.size(), 0);
    check("hold40_sw", sw, exp_sw);

    // Two short presses: sw 1->0 then 0->1.
    do_press("short1", 10);
    do_press("short2", 10);

    // Bounce: toggles every 2 cycles, never DB stable samples.
    a = cyc;
    for (int i = 0; i < 6; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_to(a + 2 * (i + 1));
    end
    btn_n = 1'b1;
    wait_to(a + 24);
    check("bounce_drain", sb_q.size(), 0);
    check("bounce_sw", sw, exp_sw);
    check("bounce_level", btn_level, 0);

    // Release accepted one cycle before the long edge: still short.
    do_press("edge19", 19);
    // Release accepted on the long edge: long only, then re-debounced release.
    do_press("simul20", 20);
    // Release accepted one cycle after the long edge.
    do_press("late21", 21);
    do_press("hold40", 40);

    // Reset mid-press at hold_cnt=10; the press is discarded.
    a = cyc;
    btn_n = 1'b0;
    push_ev("mid_rise", a + 2 + DB, {exp_sw, 3'b100});
    wait_to(a + 2 + DB + 10);
    rst_n = 1'b0;
    btn_n = 1'b1;
    exp_sw = 1'b1;
    push_ev("mid_reset", a + 2 + DB + 11, 4'b1000);
    @(negedge clk);
    check("midrst_sw", sw, 1);
    check("midrst_level", btn_level, 0);
    check("midrst_short", short_pulse, 0);
    check("midrst_long", long_pulse, 0);
    rst_n = 1'b1;
    wait_to(cyc + 12);
    check("midrst_drain", sb_q.size(), 0);

    // Clean press afterwards behaves normally.
    do_press("post_rst", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
